// File: rtl/mul8x8_seq_ctrl_if.sv
// Handshake and result bundle for the sequential 8x8 multiplier controller.
// The requester drives start/a/b; the controller returns status, selects and product.
interface mul8x8_seq_ctrl_if;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        busy;
    logic        done;
    logic [15:0] product;
    logic        sel_a;
    logic        sel_b;

    modport master (
        output start, a, b,
        input  busy, done, product, sel_a, sel_b
    );

    modport slave (
        input  start, a, b,
        output busy, done, product, sel_a, sel_b
    );
endinterface

// File: rtl/mul8x8_seq_ctrl.sv
// Sequential 8x8 unsigned multiplier: four 4x4 partial products through a
// shared nibble-select path, shift-accumulated into a 16-bit product.
module mul8x8_seq_ctrl (
    input  logic              clk,
    input  logic              rst,
    mul8x8_seq_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [7:0]  a_q;
    logic [7:0]  b_q;
    logic [15:0] acc;
    logic [15:0] product_q;
    logic [1:0]  step;

    logic        sel_a;
    logic        sel_b;
    logic [3:0]  nib_a;
    logic [3:0]  nib_b;
    logic [7:0]  pp;
    logic [1:0]  shift_nibs;
    logic [15:0] pp_shifted;
    logic [15:0] sum;

    // Selects are forced low outside CALC so the shared muxes idle on [3:0].
    always_comb begin
        sel_a      = (state == CALC) & step[0];
        sel_b      = (state == CALC) & step[1];
        nib_a      = sel_a ? a_q[7:4] : a_q[3:0];
        nib_b      = sel_b ? b_q[7:4] : b_q[3:0];
        pp         = {4'h0, nib_a} * {4'h0, nib_b};
        shift_nibs = {1'b0, sel_a} + {1'b0, sel_b};
        pp_shifted = {8'h00, pp} << {shift_nibs, 2'b00};
        sum        = acc + pp_shifted;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            step      <= 2'd0;
            acc       <= 16'h0000;
            a_q       <= 8'h00;
            b_q       <= 8'h00;
            product_q <= 16'h0000;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        a_q   <= bus.a;
                        b_q   <= bus.b;
                        acc   <= 16'h0000;
                        step  <= 2'd0;
                        state <= CALC;
                    end else begin
                        state <= IDLE;
                    end
                end
                CALC: begin
                    acc  <= sum;
                    step <= step + 2'd1;
                    if (step == 2'd3) begin
                        product_q <= sum;
                        state     <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy    = (state == CALC);
    assign bus.done    = (state == DONE);
    assign bus.product = product_q;
    assign bus.sel_a   = sel_a;
    assign bus.sel_b   = sel_b;
endmodule

// File: tb/tb_mul8x8_seq_ctrl.sv
// Directed bench for mul8x8_seq_ctrl: vector table plus hand-written
// back-to-back, ignored-input and reset sequences.
module tb_mul8x8_seq_ctrl;
    logic clk;
    logic rst;

    mul8x8_seq_ctrl_if bus ();

    mul8x8_seq_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
    } vec_t;

    vec_t        vt [8];
    int          total;
    int          bad;
    logic [15:0] last_p;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    // Caller has already set start/a/b for the accepting edge.
    task automatic run_op(input logic [15:0] exp, input bit noise,
                          input bit nxt, input logic [7:0] na,
                          input logic [7:0] nb, input string nm);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk({nm, "_busy"}, {31'b0, bus.busy}, 32'd1);
            chk({nm, "_done_calc"}, {31'b0, bus.done}, 32'd0);
            chk({nm, "_sel"}, {30'b0, bus.sel_b, bus.sel_a}, k);
            chk({nm, "_hold"}, {16'b0, bus.product}, {16'b0, last_p});
            if (noise) begin
                bus.start = 1'b1;
                bus.a     = 8'($urandom);
                bus.b     = 8'($urandom);
            end else begin
                bus.start = 1'b0;
            end
        end
        @(negedge clk);
        chk({nm, "_done"}, {31'b0, bus.done}, 32'd1);
        chk({nm, "_busy_done"}, {31'b0, bus.busy}, 32'd0);
        chk({nm, "_sel_done"}, {30'b0, bus.sel_b, bus.sel_a}, 32'd0);
        chk({nm, "_product"}, {16'b0, bus.product}, {16'b0, exp});
        last_p    = exp;
        bus.start = nxt;
        bus.a     = na;
        bus.b     = nb;
    endtask

    task automatic idle_check(input string nm, input int cycles);
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            chk({nm, "_done"}, {31'b0, bus.done}, 32'd0);
            chk({nm, "_busy"}, {31'b0, bus.busy}, 32'd0);
            chk({nm, "_prod"}, {16'b0, bus.product}, {16'b0, last_p});
        end
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        last_p = 16'h0000;

        vt[0] = '{8'h12, 8'h34, 16'h03A8};
        vt[1] = '{8'hFF, 8'hFF, 16'hFE01};
        vt[2] = '{8'h00, 8'hA5, 16'h0000};
        vt[3] = '{8'h80, 8'h02, 16'h0100};
        vt[4] = '{8'hAB, 8'hCD, 16'h88EF};
        vt[5] = '{8'h7F, 8'h81, 16'h3FFF};
        vt[6] = '{8'h01, 8'hFF, 16'h00FF};
        vt[7] = '{8'h0F, 8'h0F, 16'h00E1};

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = 8'h00;
        bus.b     = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'b0, bus.busy}, 32'd0);
        chk("rst_done", {31'b0, bus.done}, 32'd0);
        chk("rst_prod", {16'b0, bus.product}, 32'd0);
        chk("rst_sel", {30'b0, bus.sel_b, bus.sel_a}, 32'd0);
        rst = 1'b0;
        idle_check("idle0", 2);

        for (int i = 0; i < 8; i++) begin
            bus.start = 1'b1;
            bus.a     = vt[i].a;
            bus.b     = vt[i].b;
            run_op(vt[i].p, 1'b0, 1'b0, 8'h00, 8'h00,
                   $sformatf("vec%0d", i));
            idle_check($sformatf("vec%0d_after", i), 1);
        end

        // start and operand noise while busy must not disturb the result
        bus.start = 1'b1;
        bus.a     = 8'h0F;
        bus.b     = 8'h0F;
        run_op(16'h00E1, 1'b1, 1'b0, 8'h01, 8'h01, "noise");
        idle_check("noise_after", 3);

        // back-to-back accept from DONE
        bus.start = 1'b1;
        bus.a     = 8'h10;
        bus.b     = 8'h10;
        run_op(16'h0100, 1'b0, 1'b1, 8'h03, 8'h05, "b2b1");
        run_op(16'h000F, 1'b0, 1'b0, 8'h00, 8'h00, "b2b2");
        idle_check("b2b_after", 2);

        // reset mid-CALC: abort after edge N+2
        bus.start = 1'b1;
        bus.a     = 8'h12;
        bus.b     = 8'h34;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_busy_pre", {31'b0, bus.busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", {31'b0, bus.busy}, 32'd0);
        chk("abort_done", {31'b0, bus.done}, 32'd0);
        chk("abort_prod", {16'b0, bus.product}, 32'd0);
        chk("abort_sel", {30'b0, bus.sel_b, bus.sel_a}, 32'd0);
        last_p = 16'h0000;
        idle_check("abort_after", 6);
        bus.start = 1'b1;
        bus.a     = 8'hAB;
        bus.b     = 8'hCD;
        run_op(16'h88EF, 1'b0, 1'b0, 8'h00, 8'h00, "post_abort");
        idle_check("post_abort_after", 1);

        // reset and start on the same edge: reset wins
        rst       = 1'b1;
        bus.start = 1'b1;
        bus.a     = 8'hFF;
        bus.b     = 8'hFF;
        @(negedge clk);
        rst       = 1'b0;
        bus.start = 1'b0;
        last_p    = 16'h0000;
        chk("rs_busy", {31'b0, bus.busy}, 32'd0);
        chk("rs_prod", {16'b0, bus.product}, 32'd0);
        idle_check("rs_after", 6);
        bus.start = 1'b1;
        bus.a     = 8'h03;
        bus.b     = 8'h05;
        run_op(16'h000F, 1'b0, 1'b0, 8'h00, 8'h00, "rs_later");
        idle_check("rs_later_after", 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mul8x8_seq_ctrl.md
# mul8x8_seq_ctrl

Sequential 8x8 unsigned multiplier controller for the 8x8mul datapath. It latches two 8-bit operands on a start request and forms the 16-bit product in four steps. Each step takes one nibble of each operand through the shared 4-bit nibble-select path, forms one 4x4 partial product, and shift-accumulates it. It exposes the nibble selects it drives, so the shared 8-to-4 nibble muxes can be observed and reused, and it reports completion with a one-cycle done pulse.

## Interface
- Parameters: none. Widths are fixed: 8-bit operands, 4-bit nibbles, 16-bit product.
- clk  input  1  single system clock; all state updates on the rising edge
- rst  input  1  reset, synchronous, active-high
- start  input  1  request; sampled only in IDLE or DONE
- a  input  8  multiplicand; latched on the accepting edge
- b  input  8  multiplier; latched on the accepting edge
- busy  output  1  high while in CALC
- done  output  1  one-cycle pulse when product updates
- product  output  16  registered result; held until the next completion
- sel_a  output  1  nibble select for operand A: 0 = [3:0], 1 = [7:4]
- sel_b  output  1  nibble select for operand B: 0 = [3:0], 1 = [7:4]

## Operation
- States: IDLE, CALC, DONE. Internal regs: a_q[7:0], b_q[7:0], acc[15:0], step[1:0].
- IDLE: if start=1, latch a_q<=a, b_q<=b, acc<=0, step<=0, and go to CALC. Otherwise stay in IDLE.
- CALC: sel_a=step[0], sel_b=step[1] (combinational from step).
  - nib_a = sel_a ? a_q[7:4] : a_q[3:0]; nib_b = sel_b ? b_q[7:4] : b_q[3:0].
  - pp[7:0] = nib_a*nib_b (unsigned).
  - Shift = 4*(sel_a+sel_b), so the step order is: step0 (L,L) <<0, step1 (H,L) <<4, step2 (L,H) <<4, step3 (H,H) <<8.
  - Each edge: acc <= acc + (pp zero-extended to 16 bits, then shifted); step <= step+1.
  - On step=3: product <= acc + (pp<<8), state <= DONE. step wraps to 0.
- DONE: done=1 for exactly this one cycle.
  - If start=1: accept a new operation exactly as in IDLE and go to CALC.
  - Else: go to IDLE.
- Arithmetic: 16-bit accumulation never overflows, since the maximum is 255*255 = 0xFE01. No carry-out is kept.
- start in CALC is ignored. Changes on a/b during CALC are ignored, because the latched copies are used.
- In IDLE and DONE: sel_a=sel_b=0 and busy=0.
- Reset (any state, including mid-CALC):
  - state=IDLE, step=0, acc=0, a_q=b_q=0, product=0.
  - Outputs: done=0, busy=0, sel_a=sel_b=0.
  - An aborted operation produces no done and leaves product at 0.
- rst has priority over start on the same edge.

## Timing
- Start accepted at edge N (state IDLE or DONE, start=1).
- busy is high from after edge N until edge N+4.
- Partial products 0..3 are accumulated at edges N+1..N+4.
- product updates at edge N+4. done is high for the cycle between edges N+4 and N+5.
- Latency: 4 cycles from the accepting edge to product valid.
- Throughput: back-to-back starts are accepted every 5 cycles (the DONE-state accept).
- sel_a/sel_b sequence during the CALC cycles after N, N+1, N+2, N+3: (0,0), (1,0), (0,1), (1,1).
- product is stable at all times except the completion edge.
- done and busy are never high together.

## Test plan
- Basic: a=0x12, b=0x34, start pulsed at edge N.
  - sel sequence is (0,0), (1,0), (0,1), (1,1).
  - done pulses once after edge N+4, with product=0x03A8.
- Extremes:
  - 0xFF*0xFF gives product=0xFE01.
  - 0x00*0xA5 gives 0x0000 with done still pulsed.
  - 0x80*0x02 gives 0x0100.
- Ignored inputs: while busy, assert start with a=0x01, b=0x01 and change a/b every cycle.
  - The in-flight result for 0x0F*0x0F is 0x00E1.
  - No extra done pulse appears.
- Back-to-back: hold start=1 with 0x10*0x10 then 0x03*0x05.
  - done pulses at N+4 (0x0100) and N+9 (0x000F).
  - busy is low only during the done cycles.
- Reset mid-CALC: assert rst after edge N+2.
  - The next cycle shows busy=0, done=0, product=0x0000, sel=0.
  - A new start then completes normally with the correct product.
- Reset vs start: rst=1 and start=1 on the same edge, then rst=0.
  - State remains IDLE and no done occurs until a later start.
